// File: rtl/flex_sipo_framer.sv
// Serial-to-parallel shift register with a runtime frame length, a held output word,
// a valid/ack handshake and a sticky overrun flag.
module flex_sipo_framer #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 0,
    localparam int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic [CNT_W-1:0]    frame_len,
    input  logic                data_ack,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [CNT_W-1:0]    bit_count,
    output logic [NUM_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                overrun
);

    localparam logic [CNT_W-1:0] NB_C = CNT_W'(NUM_BITS);

    logic [CNT_W-1:0]    eff_len;
    logic [CNT_W-1:0]    count_inc;
    logic                complete;
    logic [NUM_BITS-1:0] shift_next;
    logic [NUM_BITS-1:0] capture;

    // Out-of-range frame lengths (0 or wider than the register) mean a full-width frame.
    always_comb begin
        eff_len   = ((frame_len == '0) || (frame_len > NB_C)) ? NB_C : frame_len;
        count_inc = bit_count + 1'b1;
        complete  = shift_enable && (count_inc >= eff_len);
    end

    generate
        if (SHIFT_MSB != 0) begin : g_msb
            logic [NUM_BITS-1:0] len_mask;
            for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_mask
                assign len_mask[gi] = (CNT_W'(gi) < eff_len);
            end
            assign shift_next = {parallel_out[NUM_BITS-2:0], serial_in};
            assign capture    = shift_next & len_mask;
        end else begin : g_lsb
            // The frame sits in the top L bits; slide it down so it is right-aligned.
            logic [CNT_W-1:0] pad_len;
            assign pad_len    = NB_C - eff_len;
            assign shift_next = {serial_in, parallel_out[NUM_BITS-1:1]};
            assign capture    = shift_next >> pad_len;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
            bit_count    <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            parallel_out <= '1;
            bit_count    <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (shift_enable) begin
                parallel_out <= shift_next;
                bit_count    <= complete ? '0 : count_inc;
            end
            // A completing frame always wins over an ack in the same cycle.
            if (complete) begin
                data_out   <= capture;
                data_valid <= 1'b1;
                if (data_valid && !data_ack) begin
                    overrun <= 1'b1;
                end
            end else if (data_ack && data_valid) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flex_sipo_framer.sv
// Bench for flex_sipo_framer: LSB-first and MSB-first instances share stimulus and are
// checked against a vector table, directed sequences and a bit-queue reference model.
module tb_flex_sipo_framer;

    localparam int NB = 8;
    localparam int CW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          clear, shift_enable, serial_in, data_ack;
    logic [CW-1:0] frame_len;
    logic [NB-1:0] po_l, po_m, d_l, d_m;
    logic [CW-1:0] bc_l, bc_m;
    logic          dv_l, dv_m, ov_l, ov_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flex_sipo_framer #(.NUM_BITS(NB), .SHIFT_MSB(0)) u_lsb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .frame_len(frame_len), .data_ack(data_ack),
        .parallel_out(po_l), .bit_count(bc_l), .data_out(d_l),
        .data_valid(dv_l), .overrun(ov_l)
    );

    flex_sipo_framer #(.NUM_BITS(NB), .SHIFT_MSB(1)) u_msb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .frame_len(frame_len), .data_ack(data_ack),
        .parallel_out(po_m), .bit_count(bc_m), .data_out(d_m),
        .data_valid(dv_m), .overrun(ov_m)
    );

    // Reference model: line history (index 0 = newest bit) and the bits of the open frame.
    bit            m_hist[NB];
    bit            m_fq[$];
    logic [NB-1:0] m_dl, m_dm;
    logic          m_dv, m_ov, m_done;

    function automatic int eff(input int f);
        return (f == 0 || f > NB) ? NB : f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_hist[i] = 1'b1;
        m_fq.delete();
        m_dl = '0; m_dm = '0; m_dv = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic s, input logic b,
                              input logic a, input int f);
        int len;
        m_done = 1'b0;
        if (c) begin
            model_reset();
        end else if (s) begin
            for (int i = NB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = b;
            m_fq.push_back(b);
            len = eff(f);
            if (m_fq.size() >= len) begin
                m_dl = '0; m_dm = '0;
                // LSB-first line: first bit is the word LSB; MSB-first: first bit is bit L-1.
                for (int i = 0; i < len; i++) begin
                    m_dl[i]         = m_fq[i];
                    m_dm[len-1-i]   = m_fq[i];
                end
                if (m_dv && !a) m_ov = 1'b1;
                m_dv = 1'b1;
                m_fq.delete();
                m_done = 1'b1;
            end else if (a && m_dv) begin
                m_dv = 1'b0;
            end
        end else if (a && m_dv) begin
            m_dv = 1'b0;
        end
    endtask

    function automatic logic [NB-1:0] exp_po(input bit msb);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            if (msb) p[i] = m_hist[i];
            else     p[NB-1-i] = m_hist[i];
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic c, input logic s, input logic b,
                        input logic a, input int f);
        clear = c; shift_enable = s; serial_in = b; data_ack = a; frame_len = CW'(f);
        @(posedge clk);
        model_step(c, s, b, a, f);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [NB-1:0] pl, input logic [NB-1:0] pm,
                           input int bc, input logic [NB-1:0] dl, input logic [NB-1:0] dm,
                           input logic dv, input logic ov);
        chk({tag, ".po_l"}, po_l, pl);
        chk({tag, ".po_m"}, po_m, pm);
        chk({tag, ".bc_l"}, bc_l, bc);
        chk({tag, ".bc_m"}, bc_m, bc);
        chk({tag, ".d_l"},  d_l,  dl);
        chk({tag, ".d_m"},  d_m,  dm);
        chk({tag, ".dv_l"}, dv_l, dv);
        chk({tag, ".dv_m"}, dv_m, dv);
        chk({tag, ".ov_l"}, ov_l, ov);
        chk({tag, ".ov_m"}, ov_m, ov);
    endtask

    typedef struct {
        logic          clr, se, sin, ack;
        int            flen;
        logic          chk_po;
        logic [NB-1:0] po_l, po_m;
        int            bc;
        logic [NB-1:0] d_l, d_m;
        logic          dv, ov;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mkv(input logic c, input logic s, input logic b, input logic a,
                                 input int f, input logic k, input logic [NB-1:0] pl,
                                 input logic [NB-1:0] pm, input int bc, input logic [NB-1:0] dl,
                                 input logic [NB-1:0] dm, input logic dv, input logic ov);
        vec_t v;
        v.clr = c; v.se = s; v.sin = b; v.ack = a; v.flen = f; v.chk_po = k;
        v.po_l = pl; v.po_m = pm; v.bc = bc; v.d_l = dl; v.d_m = dm; v.dv = dv; v.ov = ov;
        return v;
    endfunction

    initial begin
        // Short 5-bit frame from reset, then ack
        vecs[0]  = mkv(0, 1, 1, 0, 5, 1, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mkv(0, 1, 1, 0, 5, 1, 8'hFF, 8'hFF, 2, 8'h00, 8'h00, 0, 0);
        vecs[2]  = mkv(0, 1, 0, 0, 5, 1, 8'h7F, 8'hFE, 3, 8'h00, 8'h00, 0, 0);
        vecs[3]  = mkv(0, 1, 1, 0, 5, 1, 8'hBF, 8'hFD, 4, 8'h00, 8'h00, 0, 0);
        vecs[4]  = mkv(0, 1, 0, 0, 5, 1, 8'h5F, 8'hFA, 0, 8'h0B, 8'h1A, 1, 0);
        vecs[5]  = mkv(0, 0, 0, 1, 8, 1, 8'h5F, 8'hFA, 0, 8'h0B, 8'h1A, 0, 0);
        // Full 8-bit frame 1,0,1,1,0,0,1,0
        vecs[6]  = mkv(0, 1, 1, 0, 8, 1, 8'hAF, 8'hF5, 1, 8'h0B, 8'h1A, 0, 0);
        vecs[7]  = mkv(0, 1, 0, 0, 8, 1, 8'h57, 8'hEA, 2, 8'h0B, 8'h1A, 0, 0);
        vecs[8]  = mkv(0, 1, 1, 0, 8, 1, 8'hAB, 8'hD5, 3, 8'h0B, 8'h1A, 0, 0);
        vecs[9]  = mkv(0, 1, 1, 0, 8, 1, 8'hD5, 8'hAB, 4, 8'h0B, 8'h1A, 0, 0);
        vecs[10] = mkv(0, 1, 0, 0, 8, 1, 8'h6A, 8'h56, 5, 8'h0B, 8'h1A, 0, 0);
        vecs[11] = mkv(0, 1, 0, 0, 8, 1, 8'h35, 8'hAC, 6, 8'h0B, 8'h1A, 0, 0);
        vecs[12] = mkv(0, 1, 1, 0, 8, 1, 8'h9A, 8'h59, 7, 8'h0B, 8'h1A, 0, 0);
        vecs[13] = mkv(0, 1, 0, 0, 8, 1, 8'h4D, 8'hB2, 0, 8'h4D, 8'hB2, 1, 0);
        // Second frame 1,0,1,0,0,1,0,1 without ack -> overrun
        vecs[14] = mkv(0, 1, 1, 0, 8, 0, 8'h00, 8'h00, 1, 8'h4D, 8'hB2, 1, 0);
        vecs[15] = mkv(0, 1, 0, 0, 8, 0, 8'h00, 8'h00, 2, 8'h4D, 8'hB2, 1, 0);
        vecs[16] = mkv(0, 1, 1, 0, 8, 0, 8'h00, 8'h00, 3, 8'h4D, 8'hB2, 1, 0);
        vecs[17] = mkv(0, 1, 0, 0, 8, 0, 8'h00, 8'h00, 4, 8'h4D, 8'hB2, 1, 0);
        vecs[18] = mkv(0, 1, 0, 0, 8, 0, 8'h00, 8'h00, 5, 8'h4D, 8'hB2, 1, 0);
        vecs[19] = mkv(0, 1, 1, 0, 8, 0, 8'h00, 8'h00, 6, 8'h4D, 8'hB2, 1, 0);
        vecs[20] = mkv(0, 1, 0, 0, 8, 0, 8'h00, 8'h00, 7, 8'h4D, 8'hB2, 1, 0);
        vecs[21] = mkv(0, 1, 1, 0, 8, 1, 8'hA5, 8'hA5, 0, 8'hA5, 8'hA5, 1, 1);
        vecs[22] = mkv(0, 0, 0, 1, 8, 1, 8'hA5, 8'hA5, 0, 8'hA5, 8'hA5, 0, 1);
        vecs[23] = mkv(0, 0, 0, 1, 8, 1, 8'hA5, 8'hA5, 0, 8'hA5, 8'hA5, 0, 1);
        // Clear beats shift and ack
        vecs[24] = mkv(1, 1, 0, 1, 8, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 0, 0);

        n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
        data_ack = 1'b0; frame_len = CW'(8);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 0, 0);
        #2 n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tick(vecs[i].clr, vecs[i].se, vecs[i].sin, vecs[i].ack, vecs[i].flen);
            if (vecs[i].chk_po) begin
                chk($sformatf("v%0d.po_l", i), po_l, vecs[i].po_l);
                chk($sformatf("v%0d.po_m", i), po_m, vecs[i].po_m);
            end
            chk($sformatf("v%0d.bc_l", i), bc_l, vecs[i].bc);
            chk($sformatf("v%0d.bc_m", i), bc_m, vecs[i].bc);
            chk($sformatf("v%0d.d_l", i),  d_l,  vecs[i].d_l);
            chk($sformatf("v%0d.d_m", i),  d_m,  vecs[i].d_m);
            chk($sformatf("v%0d.dv_l", i), dv_l, vecs[i].dv);
            chk($sformatf("v%0d.dv_m", i), dv_m, vecs[i].dv);
            chk($sformatf("v%0d.ov_l", i), ov_l, vecs[i].ov);
            chk($sformatf("v%0d.ov_m", i), ov_m, vecs[i].ov);
            $display("vec %0d: se=%0b sin=%0b ack=%0b clr=%0b -> po_l=%h po_m=%h bc=%0d d_l=%h d_m=%h dv=%0b ov=%0b",
                     i, vecs[i].se, vecs[i].sin, vecs[i].ack, vecs[i].clr,
                     po_l, po_m, bc_l, d_l, d_m, dv_l, ov_l);
        end

        // Ack coincident with completion keeps data_valid and raises no overrun
        tick(0, 1, 1, 0, 2);
        tick(0, 1, 0, 0, 2);
        chk("seqA.dv", dv_l, 1'b1);
        chk("seqA.d_l", d_l, 8'h01);
        chk("seqA.d_m", d_m, 8'h02);
        tick(0, 1, 1, 0, 2);
        tick(0, 1, 1, 1, 2);
        chk("seqB.dv_l", dv_l, 1'b1);
        chk("seqB.dv_m", dv_m, 1'b1);
        chk("seqB.ov_l", ov_l, 1'b0);
        chk("seqB.ov_m", ov_m, 1'b0);
        chk("seqB.d_l", d_l, 8'h03);
        chk("seqB.d_m", d_m, 8'h03);
        $display("seq ack-at-completion: dv=%0b ov=%0b d_l=%h d_m=%h", dv_l, ov_l, d_l, d_m);
        tick(0, 1, 0, 0, 2);
        tick(0, 1, 1, 0, 2);
        chk("seqC.ov", ov_l, 1'b1);
        chk("seqC.d_l", d_l, 8'h02);
        chk("seqC.d_m", d_m, 8'h01);
        tick(1, 1, 1, 1, 2);
        chk_all("seqD.clear", 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 0, 0);
        $display("seq clear-priority: po_l=%h bc=%0d dv=%0b ov=%0b", po_l, bc_l, dv_l, ov_l);

        // Asynchronous reset mid-frame with a pending word
        tick(0, 1, 1, 0, 2);
        tick(0, 1, 1, 0, 2);
        tick(0, 1, 0, 0, 2);
        chk("seqE.pre_dv", dv_l, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk_all("seqE.async", 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 0, 0);
        $display("seq async reset: po_l=%h bc=%0d d_l=%h dv=%0b ov=%0b", po_l, bc_l, d_l, dv_l, ov_l);
        @(posedge clk);
        #3 n_rst = 1'b1;
        model_reset();

        // Randomized traffic against the model, frame_len only changed between frames
        begin
            int f = 8;
            for (int n = 0; n < 3000; n++) begin
                logic c, s, b, a;
                if (m_fq.size() == 0 && $urandom_range(3) == 0) f = $urandom_range(15);
                c = ($urandom_range(99) == 0);
                s = ($urandom_range(9) < 7);
                b = 1'($urandom);
                a = ($urandom_range(3) == 0);
                tick(c, s, b, a, f);
                chk_all($sformatf("rnd%0d", n), exp_po(1'b0), exp_po(1'b1), m_fq.size(),
                        m_dl, m_dm, m_dv, m_ov);
                if (m_done)
                    $display("rnd %0d: frame L=%0d d_l=%h d_m=%h dv=%0b ov=%0b",
                             n, eff(f), d_l, d_m, dv_l, ov_l);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flex_sipo_framer.md
# flex_sipo_framer

Parametrised serial-to-parallel shift register with a built-in bit counter, a runtime-selectable frame length, and a held output word with valid/ack handshake and overrun detection. It is the next-generation SIPO for the UART receiver datapath. It assembles a frame of 1..NUM_BITS serial bits, presents it right-aligned on a stable output register, and raises an overrun flag if the consumer does not take the word before the next frame completes.

## Interface
- NUM_BITS, 8, shift register and maximum frame width (>= 2)
- SHIFT_MSB, 0, 1: new bit enters bit 0 and shifts toward MSB (MSB-first line); 0: new bit enters bit NUM_BITS-1 and shifts toward LSB (LSB-first line)
- CNT_W (localparam), $clog2(NUM_BITS+1), counter / frame_len width
- clk  input  1  clock
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of all state
- shift_enable  input  1  shift serial_in in this cycle
- serial_in  input  1  serial data bit
- frame_len  input  CNT_W  bits per frame; 0 or >NUM_BITS treated as NUM_BITS; must be stable while bit_count != 0
- data_ack  input  1  consumer takes data_out
- parallel_out  output  NUM_BITS  raw shift register contents
- bit_count  output  CNT_W  bits received in the current frame
- data_out  output  NUM_BITS  last completed frame, right-aligned, zero-filled above frame_len
- data_valid  output  1  data_out holds an unacknowledged frame
- overrun  output  1  sticky; a frame completed while data_valid was high and not acked

## Operation
- Reset (n_rst low, async): parallel_out = all ones (idle line), bit_count = 0, data_out = 0, data_valid = 0, overrun = 0.
- clear (sync) restores the same values as reset. It has priority over shift_enable and data_ack.
- Shift, when shift_enable is high:
  - SHIFT_MSB=1: parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB=0: parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]}.
  - When shift_enable is low, parallel_out holds.
- Counter:
  - On a shift, bit_count increments.
  - When the increment would reach the effective frame length L, bit_count returns to 0 and the frame completes.
- Capture on completion, using the post-shift value S:
  - SHIFT_MSB=1: data_out = S with bits [NUM_BITS-1:L] forced to 0.
  - SHIFT_MSB=0: data_out = S >> (NUM_BITS-L), logical shift.
- Handshake:
  - data_valid sets on completion.
  - data_valid clears on a clock edge where data_ack=1, data_valid=1 and no completion occurs in the same cycle.
  - data_ack while data_valid=0 is ignored.
- Simultaneous events:
  - Completion with data_valid=1 and data_ack=1: data_out takes the new word, data_valid stays 1, no overrun.
  - Completion with data_valid=1 and data_ack=0: data_out is overwritten with the new word, data_valid stays 1, overrun <= 1.
- overrun clears only on clear or reset.
- parallel_out is not cleared between frames. The shift register keeps running across frame boundaries.

## Timing
- All state is updated on the rising clk edge, except the asynchronous reset.
- Latency: data_valid and data_out update on the same edge that samples the L-th shift_enable of the frame. They are visible in the following cycle.
- bit_count reads 0 in the cycle after completion.
- Back-to-back shifts every cycle are supported. Minimum frame period is L cycles.
- Reset asserted mid-frame discards the partial frame and any pending word immediately.

## Test plan
- Reset check:
  - Stimulus: NUM_BITS=8, assert n_rst low mid-shift.
  - Response: parallel_out=0xFF, bit_count=0, data_out=0x00, data_valid=0, overrun=0, all asynchronously.
- LSB-first full frame:
  - Stimulus: SHIFT_MSB=0, frame_len=8, shift 1,0,1,0,0,1,0,1 on consecutive cycles.
  - Response: data_out=0xA5 and data_valid=1 one cycle after the 8th shift edge; bit_count=0.
- MSB-first full frame:
  - Stimulus: SHIFT_MSB=1, frame_len=8, shift 1,0,1,1,0,0,1,0.
  - Response: parallel_out=0xB2, data_out=0xB2.
- Short frame:
  - Stimulus: SHIFT_MSB=0, frame_len=5 from reset, shift 1,1,0,1,0.
  - Response: parallel_out=0x5F, data_out=0x0B, data_valid=1.
- Handshake and overrun:
  - Stimulus: complete frame A, hold data_ack=0, complete frame B.
  - Response: data_out=B, data_valid=1, overrun=1.
  - Follow-up: assert data_ack one cycle; data_valid=0, overrun stays 1 until clear.
- Ack coincident with completion, and clear priority:
  - Stimulus 1: data_ack=1 on the edge of the next completion.
  - Response 1: data_valid stays 1, overrun unchanged.
  - Stimulus 2: clear=1 with shift_enable=1 and data_ack=1.
  - Response 2: all outputs return to reset values.
